// File: rtl/shift_word_feeder_pkg.sv
// Shared definitions for the serial word feeder: FSM encodings, default word width
// and counter sizing helpers.
package shift_word_feeder_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int GAP_CNT_W     = 4;

    typedef enum logic [1:0] {
        FSM_IDLE  = 2'd0,
        FSM_SHIFT = 2'd1,
        FSM_GAP   = 2'd2
    } fsm_state_t;

    // Bit counter must cover 0..width-1; never collapse to zero bits.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/word_hold_buf.sv
// One-entry valid/ready holding register; ready depends only on its own fill state
// and reset, never on in_valid.
module word_hold_buf #(
    parameter int DW = 9
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          out_take,
    output logic          out_full,
    output logic [DW-1:0] out_data
);

    logic          full_reg;
    logic [DW-1:0] data_reg;

    assign in_ready = !full_reg && !rst;
    assign out_full = full_reg;
    assign out_data = data_reg;

    // Accept and take are mutually exclusive: a full buffer never shows ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            full_reg <= 1'b0;
        end else if (in_valid && in_ready) begin
            full_reg <= 1'b1;
        end else if (out_take) begin
            full_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            data_reg <= in_data;
        end
    end

endmodule

// File: rtl/shift_word_feeder.sv
// Parallel-to-serial feeder: takes words over valid/ready and emits one bit per clock,
// MSB- or LSB-first per word, with optional idle gap cycles after each word.
module shift_word_feeder
    import shift_word_feeder_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int GAP_CYCLES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             lsb_first,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             ser_out,
    output logic             ser_dir,
    output logic             ser_en,
    output logic             busy,
    output logic             done
);

    localparam int                     CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]       LAST_BIT = CNT_W'(WIDTH - 1);
    localparam logic [GAP_CNT_W-1:0]   GAP_LAST = (GAP_CYCLES > 0) ?
                                                  GAP_CNT_W'(GAP_CYCLES - 1) : '0;

    fsm_state_t             state_reg, state_next;
    logic [WIDTH-1:0]       shreg_reg, shreg_next;
    logic                   dir_reg, dir_next;
    logic [CNT_W-1:0]       bit_cnt_reg, bit_cnt_next;
    logic [GAP_CNT_W-1:0]   gap_cnt_reg, gap_cnt_next;

    logic                   hold_full;
    logic                   hold_take;
    logic [WIDTH:0]         hold_data;
    logic                   load;
    logic [WIDTH-1:0]       shl;
    logic [WIDTH-1:0]       shr;

    word_hold_buf #(
        .DW(WIDTH + 1)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_valid (data_valid),
        .in_ready (data_ready),
        .in_data  ({lsb_first, data_in}),
        .out_take (hold_take),
        .out_full (hold_full),
        .out_data (hold_data)
    );

    // Shift toward the end being emitted: left for MSB-first, right for LSB-first.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_shift
            if (gi == 0) begin : g_lo
                assign shl[gi] = 1'b0;
            end else begin : g_lo_mid
                assign shl[gi] = shreg_reg[gi-1];
            end
            if (gi == WIDTH - 1) begin : g_hi
                assign shr[gi] = 1'b0;
            end else begin : g_hi_mid
                assign shr[gi] = shreg_reg[gi+1];
            end
        end
    endgenerate

    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        dir_next     = dir_reg;
        bit_cnt_next = bit_cnt_reg;
        gap_cnt_next = gap_cnt_reg;
        load         = 1'b0;

        case (state_reg)
            FSM_IDLE: begin
                if (hold_full) begin
                    load = 1'b1;
                end
            end
            FSM_SHIFT: begin
                shreg_next   = dir_reg ? shr : shl;
                bit_cnt_next = bit_cnt_reg + 1'b1;
                if (bit_cnt_reg == LAST_BIT) begin
                    if (GAP_CYCLES > 0) begin
                        state_next   = FSM_GAP;
                        gap_cnt_next = '0;
                    end else if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_next = FSM_IDLE;
                    end
                end
            end
            FSM_GAP: begin
                gap_cnt_next = gap_cnt_reg + 1'b1;
                if (gap_cnt_reg == GAP_LAST) begin
                    if (hold_full) begin
                        load = 1'b1;
                    end else begin
                        state_next = FSM_IDLE;
                    end
                end
            end
            default: begin
                state_next = FSM_IDLE;
            end
        endcase

        // Loading overrides the shift and restarts the word at bit 0.
        if (load) begin
            state_next   = FSM_SHIFT;
            shreg_next   = hold_data[WIDTH-1:0];
            dir_next     = hold_data[WIDTH];
            bit_cnt_next = '0;
        end
    end

    assign hold_take = load;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= FSM_IDLE;
            shreg_reg   <= '0;
            dir_reg     <= 1'b0;
            bit_cnt_reg <= '0;
            gap_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            shreg_reg   <= shreg_next;
            dir_reg     <= dir_next;
            bit_cnt_reg <= bit_cnt_next;
            gap_cnt_reg <= gap_cnt_next;
        end
    end

    assign ser_en  = (state_reg == FSM_SHIFT);
    assign ser_out = ser_en & (dir_reg ? shreg_reg[0] : shreg_reg[WIDTH-1]);
    assign ser_dir = dir_reg;
    assign done    = ser_en && (bit_cnt_reg == LAST_BIT);
    assign busy    = (state_reg != FSM_IDLE) || hold_full;

endmodule
